osc_sequencer: RTL
==================

// Module: osc_sequencer
// PURPOSE
//  Step sequencer that drives one genSaw oscillator's control inputs (targetf, wave, pause).
//  Holds a programmable table of steps: frequency, waveform, rest flag and duration.
//  Plays the table once or looped, timed by the oscillator's own 48 kHz o_pulse.
//  Sits between the host/control logic and genSaw in the 48 MHz domain.
// PARAMETERS
//  STEPS       16  number of table entries (power of 2, >=2); IW = $clog2(STEPS)
//  GAP_PULSES  48  silent sample pulses inserted after each step (0 = no gap)
// PORTS
//  i_clk48        in   1   48 MHz clock
//  i_rst48_n      in   1   reset, asynchronous assert, active-low
//  i_wr_en        in   1   table write strobe
//  i_wr_addr      in   IW  table write index
//  i_wr_freq      in   24  step target frequency (Hz, genSaw i_targetf format)
//  i_wr_wave      in   2   step waveform select (0 saw,1 square,2 tri,3 sine)
//  i_wr_rest      in   1   1 = step is silent (pause held)
//  i_wr_dur       in   16  step duration in ms (units of 48 sample pulses)
//  i_len          in   IW+1 active steps, 1..STEPS; sampled on i_start
//  i_loop         in   1   1 = wrap to step 0 after last step (read live)
//  i_start        in   1   1-cycle start/restart strobe
//  i_stop         in   1   1-cycle stop strobe
//  i_sample_pulse in   1   genSaw o_pulse (1 cycle per 48 kHz sample)
//  o_targetf      out  24  to genSaw i_targetf
//  o_wave         out  8   to genSaw i_wave, {6'b0, wave}
//  o_pause        out  1   to genSaw i_pause
//  o_busy         out  1   high in any state except IDLE
//  o_step         out  IW  index of current/last loaded step
//  o_done         out  1   1-cycle strobe when a non-looped pass ends
// BEHAVIOUR
//  Reset: state IDLE; o_targetf=0, o_wave=0, o_pause=1, o_busy=0, o_step=0, o_done=0.
//  Table: synchronous write, registered read (1 cycle); contents not reset (X until written).
//  States: IDLE, LOAD, PLAY, GAP.
//   IDLE: o_pause=1, targetf/wave hold last values. i_start with i_len!=0 -> LOAD, idx=0.
//   LOAD: read table[idx]; next cycle latch o_targetf/o_wave/o_step, o_pause=rest.
//     dur==0 -> skip step (advance immediately, no PLAY/GAP); else -> PLAY, pulse cnt=0.
//   PLAY: count i_sample_pulse; after dur*48 pulses -> GAP (or advance if GAP_PULSES==0).
//   GAP: o_pause=1; after GAP_PULSES pulses -> advance.
//   Advance: idx<len-1 -> idx+1, LOAD. Last step: i_loop -> idx=0, LOAD;
//     else -> IDLE, o_done=1 for one cycle, o_pause=1.
//  Latency: i_start at cycle N -> LOAD at N+1 -> outputs updated at N+2.
//  Pulse counter: 22 bits (max 65535*48); only increments on i_sample_pulse in PLAY/GAP.
//  i_len sampled at start; values > STEPS clamp to STEPS; i_len==0 -> start ignored.
//  i_start while busy: restart from step 0 (new i_len), no o_done.
//  i_stop: -> IDLE next cycle, o_pause=1, no o_done. i_stop and i_start together: stop wins.
//  Write to the step being played: takes effect the next time that step is loaded.
//  Write and LOAD read of the same address in one cycle: read returns old data.
//  Reset mid-play: immediate return to reset values (async).
// STRUCTURE
//  osc_seq_pkg: state_t enum {IDLE,LOAD,PLAY,GAP}; step_t packed struct
//   {freq[23:0], wave[1:0], rest, dur[15:0]}; SAMPLES_PER_MS = 48.
//  Sub-module osc_seq_ram: STEPS x step_t, 1 write port, registered read port.
//  Top: FSM, step index, pulse counter, output registers.
// TESTING
//  1 Write step0={440,saw,0,2}, step1={880,sq,0,1}; len=2, loop=0; start
//    -> 440/wave0 for 96 pulses, 48-pulse pause, 880/wave1 for 48 pulses, gap, o_done once.
//  2 Same table, loop=1 -> step sequence 0,1,0,1...; i_stop mid-PLAY -> o_pause=1 next cycle,
//    o_busy=0, no o_done.
//  3 step1.dur=0, len=3 -> step1 skipped, o_step goes 0->2, freq never 880.
//  4 step0 rest=1, dur=1 -> o_pause held 1 for 48+GAP pulses, then step1 plays.
//  5 i_start at cycle N while playing step 2 -> o_step=0 and outputs updated at N+2;
//    start+stop same cycle -> IDLE.
//  6 Assert i_rst48_n=0 mid-PLAY, asynchronously between clocks -> outputs reach reset values
//    at once; len=0 start -> remains IDLE.

Source files
------------

// File: rtl/osc_seq_pkg.sv
// Shared types for the oscillator step sequencer: FSM states, the table entry layout
// and the conversion from a step duration in milliseconds to sample pulses.
package osc_seq_pkg;

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        PLAY,
        GAP
    } state_t;

    typedef struct packed {
        logic [23:0] freq;
        logic [1:0]  wave;
        logic        rest;
        logic [15:0] dur;
    } step_t;

    localparam int SAMPLES_PER_MS = 48;
    localparam int CNT_W          = 22;

    // 65535 ms * 48 pulses still fits the 22-bit pulse counter.
    function automatic logic [CNT_W-1:0] dur_pulses(input logic [15:0] dur);
        return CNT_W'(dur) * CNT_W'(SAMPLES_PER_MS);
    endfunction

endpackage

// File: rtl/osc_seq_if.sv
// Host-side control bus of the sequencer: step table write port plus play controls.
interface osc_seq_if #(
    parameter int STEPS = 16
);
    localparam int IW = $clog2(STEPS);

    logic          i_wr_en;
    logic [IW-1:0] i_wr_addr;
    logic [23:0]   i_wr_freq;
    logic [1:0]    i_wr_wave;
    logic          i_wr_rest;
    logic [15:0]   i_wr_dur;
    logic [IW:0]   i_len;
    logic          i_loop;
    logic          i_start;
    logic          i_stop;

    modport master (
        output i_wr_en, i_wr_addr, i_wr_freq, i_wr_wave, i_wr_rest, i_wr_dur,
        output i_len, i_loop, i_start, i_stop
    );

    modport slave (
        input i_wr_en, i_wr_addr, i_wr_freq, i_wr_wave, i_wr_rest, i_wr_dur,
        input i_len, i_loop, i_start, i_stop
    );

endinterface

// File: rtl/osc_seq_ram.sv
// Step table: one synchronous write port and one registered read port.
// A read and a write to the same entry in one cycle returns the old entry.
module osc_seq_ram
    import osc_seq_pkg::*;
#(
    parameter int  STEPS = 16,
    localparam int IW    = $clog2(STEPS)
) (
    input  logic          i_clk48,
    input  logic          wr_en,
    input  logic [IW-1:0] wr_addr,
    input  step_t         wr_data,
    input  logic [IW-1:0] rd_addr,
    output step_t         rd_data
);

    step_t mem [STEPS];

    // NOTE: the table has no reset so it maps onto plain RAM; entries are undefined until written.
    always_ff @(posedge i_clk48) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
        rd_data <= mem[rd_addr];
    end

endmodule

// File: rtl/osc_sequencer.sv
// Step sequencer feeding one genSaw oscillator with targetf, wave and pause.
// Steps are timed by the oscillator's own sample pulse and played once or looped.
module osc_sequencer
    import osc_seq_pkg::*;
#(
    parameter int  STEPS      = 16,
    parameter int  GAP_PULSES = 48,
    localparam int IW         = $clog2(STEPS)
) (
    input  logic          i_clk48,
    input  logic          i_rst48_n,
    osc_seq_if.slave      ctl,
    input  logic          i_sample_pulse,
    output logic [23:0]   o_targetf,
    output logic [7:0]    o_wave,
    output logic          o_pause,
    output logic          o_busy,
    output logic [IW-1:0] o_step,
    output logic          o_done
);

    state_t           state_q, state_d;
    logic [IW-1:0]    idx_q, idx_d;
    logic [IW:0]      len_q, len_d, len_clamp;
    logic [CNT_W-1:0] cnt_q, cnt_d, limit_q, limit_d;
    logic [23:0]      targetf_d;
    logic [1:0]       wave_q, wave_d;
    logic             pause_d;
    logic [IW-1:0]    step_d;
    logic             done_d;
    logic             last_step;
    logic             advance;
    step_t            wr_step, rd_step;

    assign wr_step   = '{freq: ctl.i_wr_freq, wave: ctl.i_wr_wave,
                         rest: ctl.i_wr_rest, dur: ctl.i_wr_dur};
    assign len_clamp = (ctl.i_len > (IW+1)'(STEPS)) ? (IW+1)'(STEPS) : ctl.i_len;
    assign last_step = ({1'b0, idx_q} + (IW+1)'(1)) == len_q;
    assign o_busy    = (state_q != IDLE);
    assign o_wave    = {6'b0, wave_q};

    // The read address is the next index, so table data is ready during the LOAD cycle.
    osc_seq_ram #(.STEPS(STEPS)) u_ram (
        .i_clk48 (i_clk48),
        .wr_en   (ctl.i_wr_en),
        .wr_addr (ctl.i_wr_addr),
        .wr_data (wr_step),
        .rd_addr (idx_d),
        .rd_data (rd_step)
    );

    always_comb begin
        // NOTE: every variable gets a default first so this process never infers a latch.
        state_d   = state_q;
        idx_d     = idx_q;
        len_d     = len_q;
        cnt_d     = cnt_q;
        limit_d   = limit_q;
        targetf_d = o_targetf;
        wave_d    = wave_q;
        pause_d   = o_pause;
        step_d    = o_step;
        done_d    = 1'b0;
        advance   = 1'b0;

        if (ctl.i_stop) begin
            state_d = IDLE;
            pause_d = 1'b1;
        end else if (ctl.i_start && (ctl.i_len != '0)) begin
            state_d = LOAD;
            idx_d   = '0;
            len_d   = len_clamp;
            cnt_d   = '0;
        end else begin
            case (state_q)
                IDLE: pause_d = 1'b1;
                LOAD: begin
                    // Zero-length steps are skipped without touching the oscillator.
                    if (rd_step.dur == '0) begin
                        advance = 1'b1;
                    end else begin
                        targetf_d = rd_step.freq;
                        wave_d    = rd_step.wave;
                        pause_d   = rd_step.rest;
                        step_d    = idx_q;
                        limit_d   = dur_pulses(rd_step.dur);
                        cnt_d     = '0;
                        state_d   = PLAY;
                    end
                end
                PLAY: begin
                    if (i_sample_pulse) begin
                        if (cnt_q + CNT_W'(1) == limit_q) begin
                            cnt_d = '0;
                            if (GAP_PULSES == 0) begin
                                advance = 1'b1;
                            end else begin
                                state_d = GAP;
                                pause_d = 1'b1;
                            end
                        end else begin
                            cnt_d = cnt_q + CNT_W'(1);
                        end
                    end
                end
                GAP: begin
                    if (i_sample_pulse) begin
                        if (cnt_q + CNT_W'(1) == CNT_W'(GAP_PULSES)) begin
                            cnt_d   = '0;
                            advance = 1'b1;
                        end else begin
                            cnt_d = cnt_q + CNT_W'(1);
                        end
                    end
                end
                default: state_d = IDLE;
            endcase

            if (advance) begin
                if (!last_step) begin
                    idx_d   = idx_q + 1'b1;
                    state_d = LOAD;
                end else if (ctl.i_loop) begin
                    idx_d   = '0;
                    state_d = LOAD;
                end else begin
                    state_d = IDLE;
                    pause_d = 1'b1;
                    done_d  = 1'b1;
                end
            end
        end
    end

    // NOTE: registers take non-blocking assignments; the combinational block above uses blocking.
    always_ff @(posedge i_clk48 or negedge i_rst48_n) begin
        if (!i_rst48_n) begin
            state_q   <= IDLE;
            idx_q     <= '0;
            len_q     <= '0;
            cnt_q     <= '0;
            limit_q   <= '0;
            o_targetf <= '0;
            wave_q    <= '0;
            o_pause   <= 1'b1;
            o_step    <= '0;
            o_done    <= 1'b0;
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            len_q     <= len_d;
            cnt_q     <= cnt_d;
            limit_q   <= limit_d;
            o_targetf <= targetf_d;
            wave_q    <= wave_d;
            o_pause   <= pause_d;
            o_step    <= step_d;
            o_done    <= done_d;
        end
    end

endmodule
